// File: rtl/float_adder_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : float_adder_arbiter_if
// Brief    : Requester and adder handshake bundle for float_adder_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface float_adder_arbiter_if #(
  parameter int P_NUM_REQ = 4,
  parameter int P_CNT_W   = 16
);
  localparam int c_GNT_W = $clog2(P_NUM_REQ);

  logic [32*P_NUM_REQ-1:0] i_REQ_A;
  logic [32*P_NUM_REQ-1:0] i_REQ_B;
  logic [P_NUM_REQ-1:0]    i_REQ_AB_STB;
  logic [P_NUM_REQ-1:0]    o_REQ_AB_ACK;
  logic [31:0]             o_REQ_Z;
  logic [P_NUM_REQ-1:0]    o_REQ_Z_STB;
  logic [P_NUM_REQ-1:0]    i_REQ_Z_ACK;
  logic [31:0]             o_ADD_A;
  logic [31:0]             o_ADD_B;
  logic                    o_ADD_AB_STB;
  logic                    i_ADD_AB_ACK;
  logic [31:0]             i_ADD_Z;
  logic                    i_ADD_Z_STB;
  logic                    o_ADD_Z_ACK;
  logic [c_GNT_W-1:0]      o_GRANT;
  logic                    o_BUSY;
  logic [P_CNT_W-1:0]      o_OP_CNT;

  modport master (
    input  i_REQ_A, i_REQ_B, i_REQ_AB_STB, i_REQ_Z_ACK,
    input  i_ADD_AB_ACK, i_ADD_Z, i_ADD_Z_STB,
    output o_REQ_AB_ACK, o_REQ_Z, o_REQ_Z_STB,
    output o_ADD_A, o_ADD_B, o_ADD_AB_STB, o_ADD_Z_ACK,
    output o_GRANT, o_BUSY, o_OP_CNT
  );

  modport slave (
    output i_REQ_A, i_REQ_B, i_REQ_AB_STB, i_REQ_Z_ACK,
    output i_ADD_AB_ACK, i_ADD_Z, i_ADD_Z_STB,
    input  o_REQ_AB_ACK, o_REQ_Z, o_REQ_Z_STB,
    input  o_ADD_A, o_ADD_B, o_ADD_AB_STB, o_ADD_Z_ACK,
    input  o_GRANT, o_BUSY, o_OP_CNT
  );
endinterface
`default_nettype wire

// File: rtl/float_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : float_adder_arbiter
// Brief    : Round-robin sharing of one float_adder among P_NUM_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module float_adder_arbiter #(
  parameter int P_NUM_REQ = 4,
  parameter int P_CNT_W   = 16
) (
  input  logic                 i_CLK,
  input  logic                 i_RSTN,
  float_adder_arbiter_if.master bus
);
  localparam int c_GNT_W = $clog2(P_NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT_Z = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_GNT_W-1:0]   r_ptr, w_ptr_nxt;
  logic [c_GNT_W-1:0]   r_grant, w_grant_nxt;
  logic [31:0]          r_add_a, w_add_a_nxt;
  logic [31:0]          r_add_b, w_add_b_nxt;
  logic                 r_add_stb, w_add_stb_nxt;
  logic                 r_add_z_ack, w_add_z_ack_nxt;
  logic [31:0]          r_req_z, w_req_z_nxt;
  logic [P_NUM_REQ-1:0] r_ab_ack, w_ab_ack_nxt;
  logic [P_NUM_REQ-1:0] r_z_stb, w_z_stb_nxt;
  logic                 r_busy, w_busy_nxt;
  logic [P_CNT_W-1:0]   r_cnt, w_cnt_nxt;

  logic [c_GNT_W-1:0]   w_win;
  logic                 w_win_vld;
  logic [c_GNT_W:0]     w_scan;
  logic [c_GNT_W-1:0]   w_idx;
  logic [31:0]          w_sel_a, w_sel_b;

  // Scan pointer+1 upward with wrap; first requesting index wins.
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    w_scan    = '0;
    w_idx     = '0;
    for (int i = 1; i <= P_NUM_REQ; i++) begin
      w_scan = {1'b0, r_ptr} + (c_GNT_W+1)'(i);
      if (w_scan >= (c_GNT_W+1)'(P_NUM_REQ)) begin
        w_scan = w_scan - (c_GNT_W+1)'(P_NUM_REQ);
      end
      w_idx = w_scan[c_GNT_W-1:0];
      if (!w_win_vld && bus.i_REQ_AB_STB[w_idx]) begin
        w_win     = w_idx;
        w_win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      if (w_win == c_GNT_W'(i)) begin
        w_sel_a = bus.i_REQ_A[32*i +: 32];
        w_sel_b = bus.i_REQ_B[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    w_add_a_nxt   = r_add_a;
    w_add_b_nxt   = r_add_b;
    w_add_stb_nxt = r_add_stb;
    w_req_z_nxt   = r_req_z;
    w_z_stb_nxt   = r_z_stb;
    w_ab_ack_nxt  = '0;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_add_a_nxt          = w_sel_a;
          w_add_b_nxt          = w_sel_b;
          w_grant_nxt          = w_win;
          w_ab_ack_nxt[w_win]  = 1'b1;
          w_add_stb_nxt        = 1'b1;
          w_state_nxt          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_add_stb && bus.i_ADD_AB_ACK) begin
          w_add_stb_nxt = 1'b0;
          w_state_nxt   = S_WAIT_Z;
        end
      end
      S_WAIT_Z: begin
        if (bus.i_ADD_Z_STB && r_add_z_ack) begin
          w_req_z_nxt          = bus.i_ADD_Z;
          w_z_stb_nxt[r_grant] = 1'b1;
          w_state_nxt          = S_RETURN;
        end
      end
      S_RETURN: begin
        if (bus.i_REQ_Z_ACK[r_grant]) begin
          w_z_stb_nxt = '0;
          w_ptr_nxt   = r_grant;
          w_cnt_nxt   = r_cnt + P_CNT_W'(1);
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Adder results are accepted everywhere but RETURN, so stale ones drain in IDLE/ISSUE.
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_add_z_ack_nxt = (w_state_nxt != S_RETURN);
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      r_state     <= S_IDLE;
      r_ptr       <= c_GNT_W'(P_NUM_REQ-1);
      r_grant     <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_stb   <= 1'b0;
      r_add_z_ack <= 1'b0;
      r_req_z     <= '0;
      r_z_stb     <= '0;
      r_ab_ack    <= '0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_add_a     <= w_add_a_nxt;
      r_add_b     <= w_add_b_nxt;
      r_add_stb   <= w_add_stb_nxt;
      r_add_z_ack <= w_add_z_ack_nxt;
      r_req_z     <= w_req_z_nxt;
      r_z_stb     <= w_z_stb_nxt;
      r_ab_ack    <= w_ab_ack_nxt;
      r_busy      <= w_busy_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign bus.o_REQ_AB_ACK = r_ab_ack;
  assign bus.o_REQ_Z      = r_req_z;
  assign bus.o_REQ_Z_STB  = r_z_stb;
  assign bus.o_ADD_A      = r_add_a;
  assign bus.o_ADD_B      = r_add_b;
  assign bus.o_ADD_AB_STB = r_add_stb;
  assign bus.o_ADD_Z_ACK  = r_add_z_ack;
  assign bus.o_GRANT      = r_grant;
  assign bus.o_BUSY       = r_busy;
  assign bus.o_OP_CNT     = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_float_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_adder_arbiter
// Brief    : Scoreboard bench for float_adder_arbiter with a behavioural adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_adder_arbiter;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam logic [31:0] WRAP_IN[4]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  localparam logic [31:0] WRAP_SUM[4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  float_adder_arbiter_if #(.P_NUM_REQ(N), .P_CNT_W(CW)) bus ();
  float_adder_arbiter #(.P_NUM_REQ(N), .P_CNT_W(CW)) dut (
    .i_CLK (clk),
    .i_RSTN(rst_n),
    .bus   (bus)
  );

  op_t         op_q[N][$];
  logic [31:0] exp_q[N][$];
  int          grant_q[$];
  logic [N-1:0] hold_zack = '0;
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else d = {s[31], 11'({3'b000, s[30:23]} + 11'd896), s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] z, input bit chk);
    op_q[k].push_back({a, b});
    if (chk) begin
      exp_q[k].push_back(z);
      grant_q.push_back(k);
    end
  endtask

  // Requesters: operand STB from per-requester queues, result ACK unless held off
  initial begin
    bus.i_REQ_A      = '0;
    bus.i_REQ_B      = '0;
    bus.i_REQ_AB_STB = '0;
    bus.i_REQ_Z_ACK  = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (bus.i_REQ_AB_STB[k] && bus.o_REQ_AB_ACK[k]) void'(op_q[k].pop_front());
        if (op_q[k].size() > 0) begin
          bus.i_REQ_AB_STB[k]     = 1'b1;
          bus.i_REQ_A[32*k +: 32] = op_q[k][0].a;
          bus.i_REQ_B[32*k +: 32] = op_q[k][0].b;
        end else begin
          bus.i_REQ_AB_STB[k] = 1'b0;
        end
      end
      bus.i_REQ_Z_ACK = bus.o_REQ_Z_STB & ~hold_zack;
    end
  end

  // Behavioural adder, three cycles of latency, always ready for operands
  initial begin
    logic [31:0] sa, sb;
    int cd;
    bit drop;
    cd = 0; drop = 1'b0; sa = '0; sb = '0;
    bus.i_ADD_AB_ACK = 1'b1;
    bus.i_ADD_Z_STB  = 1'b0;
    bus.i_ADD_Z      = '0;
    forever begin
      @(negedge clk);
      if (drop) begin
        bus.i_ADD_Z_STB = 1'b0;
        drop = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.i_ADD_Z     = r2s(s2r(sa) + s2r(sb));
          bus.i_ADD_Z_STB = 1'b1;
        end
      end else if (bus.o_ADD_AB_STB && bus.i_ADD_AB_ACK) begin
        sa = bus.o_ADD_A;
        sb = bus.o_ADD_B;
        cd = 3;
      end
      if (bus.i_ADD_Z_STB && bus.o_ADD_Z_ACK) drop = 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever a new result is presented
  initial begin
    logic [N-1:0]  prev;
    logic [CW-1:0] exp_cnt;
    int k, g;
    prev = '0; exp_cnt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_cnt = '0;
        prev    = '0;
      end else begin
        if (bus.o_REQ_Z_STB != '0 && prev == '0) begin
          k = -1;
          for (int i = 0; i < N; i++) if (bus.o_REQ_Z_STB[i] && k < 0) k = i;
          check("z_stb_onehot", 32'($onehot(bus.o_REQ_Z_STB)), 32'd1);
          if (grant_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_result: got stb %b z 0x%08h, expected none", bus.o_REQ_Z_STB, bus.o_REQ_Z);
          end else begin
            g = grant_q.pop_front();
            check("result_route", 32'(k), 32'(g));
            check("o_GRANT", 32'(bus.o_GRANT), 32'(g));
            if (exp_q[g].size() > 0) check("result_z", bus.o_REQ_Z, exp_q[g].pop_front());
          end
          check("op_cnt_at_result", 32'(bus.o_OP_CNT), 32'(exp_cnt));
          exp_cnt = exp_cnt + 1'b1;
        end
        prev = bus.o_REQ_Z_STB;
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_ab_ack"}, 32'(bus.o_REQ_AB_ACK), 32'd0);
    check({tag, "_z_stb"},  32'(bus.o_REQ_Z_STB), 32'd0);
    check({tag, "_add_stb"}, 32'(bus.o_ADD_AB_STB), 32'd0);
    check({tag, "_add_z_ack"}, 32'(bus.o_ADD_Z_ACK), 32'd0);
    check({tag, "_add_a"}, bus.o_ADD_A, 32'd0);
    check({tag, "_add_b"}, bus.o_ADD_B, 32'd0);
    check({tag, "_req_z"}, bus.o_REQ_Z, 32'd0);
    check({tag, "_grant"}, 32'(bus.o_GRANT), 32'd0);
    check({tag, "_busy"}, 32'(bus.o_BUSY), 32'd0);
    check({tag, "_op_cnt"}, 32'(bus.o_OP_CNT), 32'd0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    bit empty;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      empty = (grant_q.size() == 0);
      for (int k = 0; k < N; k++) if (op_q[k].size() != 0) empty = 1'b0;
      if (empty && bus.i_REQ_AB_STB == '0 && !bus.o_BUSY) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    logic [N-1:0] snap_stb;
    logic [31:0]  snap_z;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Single request: 1.0 + 2.0 = 3.0
    @(posedge clk); #1;
    issue(0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.o_REQ_AB_ACK != '0) seen = 1'b1;
    end
    check("single_ab_ack", 32'(bus.o_REQ_AB_ACK), 32'b0001);
    @(negedge clk);
    check("single_ab_ack_pulse", 32'(bus.o_REQ_AB_ACK), 32'd0);
    wait_idle("single_idle", 100);
    check("single_op_cnt", 32'(bus.o_OP_CNT), 32'd1);

    // Fresh reset, then all four at once: grants 0,1,2,3
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("reset2");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 32'h3FC00000, 32'h3F000000, 32'h40000000, 1'b1);
    issue(1, 32'h40400000, 32'h40800000, 32'h40E00000, 1'b1);
    issue(2, 32'h41200000, 32'hC0000000, 32'h41000000, 1'b1);
    issue(3, 32'h3E800000, 32'h3E800000, 32'h3F000000, 1'b1);
    wait_idle("all4_idle", 200);

    // Fairness: requesters 1 and 3 continuously, grants 1,3,1,3
    @(posedge clk); #1;
    issue(1, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b1);
    issue(3, 32'h40000000, 32'h40000000, 32'h40800000, 1'b1);
    issue(1, 32'h40A00000, 32'h40A00000, 32'h41200000, 1'b1);
    issue(3, 32'h41000000, 32'h3F000000, 32'h41080000, 1'b1);
    wait_idle("fair_idle", 200);

    // Backpressure on requester 2 while requester 0 waits: 100 + 28 = 128
    @(posedge clk); #1;
    hold_zack[2] = 1'b1;
    issue(2, 32'h42C80000, 32'h41E00000, 32'h43000000, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.o_REQ_Z_STB[2]) seen = 1'b1;
    end
    check("bp_result_seen", 32'(seen), 32'd1);
    snap_stb = bus.o_REQ_Z_STB;
    snap_z   = bus.o_REQ_Z;
    issue(0, 32'h3F000000, 32'h3F000000, 32'h3F800000, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_z_stb_hold", 32'(bus.o_REQ_Z_STB), 32'(snap_stb));
      check("bp_z_hold", bus.o_REQ_Z, snap_z);
      check("bp_add_z_ack", 32'(bus.o_ADD_Z_ACK), 32'd0);
      check("bp_no_grant", 32'(bus.o_REQ_AB_ACK), 32'd0);
      check("bp_busy", 32'(bus.o_BUSY), 32'd1);
    end
    hold_zack[2] = 1'b0;
    wait_idle("bp_idle", 100);

    // Reset during WAIT_Z; stale 1.0 + 1.0 must never be delivered
    @(posedge clk); #1;
    issue(0, 32'h3F800000, 32'h3F800000, 32'h0, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.o_BUSY && !bus.o_ADD_AB_STB && bus.o_REQ_Z_STB == '0) seen = 1'b1;
    end
    check("wz_reached", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_wz");
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("stale_drained", 32'(bus.i_ADD_Z_STB), 32'd0);
    check("stale_not_delivered", 32'(bus.o_REQ_Z_STB), 32'd0);
    @(posedge clk); #1;
    issue(0, 32'h40000000, 32'h40800000, 32'h40C00000, 1'b1);
    wait_idle("post_reset_idle", 100);
    check("post_reset_op_cnt", 32'(bus.o_OP_CNT), 32'd1);

    // Sixteen more operations: 4-bit counter wraps 15 -> 0, ends at 1
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      issue((i + 1) % N, WRAP_IN[(i + 1) % N], WRAP_IN[(i + 1) % N], WRAP_SUM[(i + 1) % N], 1'b1);
    end
    wait_idle("wrap_idle", 600);
    check("wrap_op_cnt", 32'(bus.o_OP_CNT), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/float_adder_arbiter.md
# float_adder_arbiter

Round-robin arbiter that shares one `float_adder` instance among `P_NUM_REQ` requesters (filter taps, accumulators) in the sensor filter datapath. Each requester sees a private STB/ACK operand port and a private STB/ACK result port. The arbiter owns the adder's handshake, serialises operations one at a time, and routes each result back to the requester that issued it.

## Interface
- `P_NUM_REQ`, default 4: number of requesters, 2..8.
- `P_CNT_W`, default 16: width of the completed-operation counter.

- `i_CLK`  in  1  clock.
- `i_RSTN`  in  1  reset; asynchronous, active-low.
- `i_REQ_A`  in  32*P_NUM_REQ  operand A; requester k in bits [32k+31:32k].
- `i_REQ_B`  in  32*P_NUM_REQ  operand B; same packing as `i_REQ_A`.
- `i_REQ_AB_STB`  in  P_NUM_REQ  operands valid, one bit per requester.
- `o_REQ_AB_ACK`  out  P_NUM_REQ  one-cycle pulse: operands taken.
- `o_REQ_Z`  out  32  result; valid while any `o_REQ_Z_STB` bit is high.
- `o_REQ_Z_STB`  out  P_NUM_REQ  one-hot result valid.
- `i_REQ_Z_ACK`  in  P_NUM_REQ  result consumed.
- `o_ADD_A`, `o_ADD_B`  out  32  operands to the adder.
- `o_ADD_AB_STB`  out  1  operands valid to the adder.
- `i_ADD_AB_ACK`  in  1  adder ready for operands.
- `i_ADD_Z`  in  32  adder result.
- `i_ADD_Z_STB`  in  1  adder result valid.
- `o_ADD_Z_ACK`  out  1  result taken from the adder.
- `o_GRANT`  out  $clog2(P_NUM_REQ)  index of the current owner.
- `o_BUSY`  out  1  high in every state except IDLE.
- `o_OP_CNT`  out  P_CNT_W  count of completed operations; wraps.

## Operation
- **Registered outputs.** All outputs are registered. Reset values: every STB/ACK output = 0, `o_ADD_A`/`o_ADD_B`/`o_REQ_Z` = 0, `o_GRANT` = 0, `o_OP_CNT` = 0, `o_BUSY` = 0. The round-robin pointer resets to `P_NUM_REQ-1`, so requester 0 has top priority first.
- **States:** IDLE, ISSUE, WAIT_Z, RETURN.
- **IDLE**
  - If any `i_REQ_AB_STB` bit is high, select winner g as the first set bit scanning from pointer+1 upward, modulo `P_NUM_REQ`.
  - Latch A/B of g into `o_ADD_A`/`o_ADD_B`, set `o_GRANT` = g, pulse `o_REQ_AB_ACK[g]` for exactly one cycle, set `o_ADD_AB_STB` = 1, go to ISSUE.
  - Losers see no ACK and keep their STB asserted.
- **ISSUE**
  - Transfer happens at the edge where `o_ADD_AB_STB` and `i_ADD_AB_ACK` are both 1.
  - On transfer: clear `o_ADD_AB_STB`, go to WAIT_Z.
- **WAIT_Z**
  - At the edge where `i_ADD_Z_STB` and `o_ADD_Z_ACK` are both 1: capture `i_ADD_Z` into `o_REQ_Z`, set `o_REQ_Z_STB[g]` = 1, go to RETURN.
- **RETURN**
  - Hold `o_REQ_Z` and `o_REQ_Z_STB[g]` until the edge where `i_REQ_Z_ACK[g]` = 1.
  - At that edge: clear STB, set pointer = g, increment `o_OP_CNT`, go to IDLE.
  - ACK bits of other requesters are ignored.
- **`o_ADD_Z_ACK`** is 1 in IDLE, ISSUE and WAIT_Z and 0 in RETURN.
  - In IDLE and ISSUE this drains any stale adder result, which is discarded. A stale result can only exist after an arbiter reset during an operation.
- **Requester obligation.** A requester drops `i_REQ_AB_STB[k]` on the edge that samples `o_REQ_AB_ACK[k]` = 1. A STB still high when the arbiter re-enters IDLE counts as a new request.
- **No pipelining.** Exactly one operation is outstanding; a new grant is made only in IDLE.

## Timing
- Grant: 1 cycle from the first edge with a STB in IDLE to `o_REQ_AB_ACK` high.
- Adder handoff: with `i_ADD_AB_ACK` already high, transfer occurs 1 edge after entering ISSUE.
- Result latency: result is visible on `o_REQ_Z` 1 cycle after the adder's STB/ACK edge.
- Best-case overhead: 4 cycles around the adder's own latency (IDLE→ISSUE→WAIT_Z→RETURN→IDLE).
- Simultaneous requests: one winner per IDLE pass; the pointer guarantees each active requester is served within `P_NUM_REQ` operations.
- Same-edge events: a requester's ACK and the adder's STB on the same edge never conflict, because they are sampled in different states.
- Reset mid-operation: async clear to IDLE with all outputs at reset values. The in-flight adder result is later drained in IDLE/ISSUE and never delivered.
- Counter wrap: `o_OP_CNT` wraps from 2^P_CNT_W-1 to 0.

## Test plan
- **Single request.** Req0: A=0x3F800000, B=0x40000000, with a behavioural adder model. Expect `o_REQ_AB_ACK`=4'b0001 for 1 cycle, `o_REQ_Z`=0x40400000 with `o_REQ_Z_STB`=4'b0001, `o_OP_CNT`=1.
- **All four requesters at once.** Requesters 0..3 all raise STB in the same cycle. Expect grants in order 0,1,2,3; each result is routed only to its own STB bit.
- **Fairness.** Req1 and req3 assert STB continuously. Expect grants to alternate 1,3,1,3; neither requester is granted twice in a row.
- **Backpressure.** Hold `i_REQ_Z_ACK` low for 10 cycles. Expect `o_REQ_Z_STB` and `o_REQ_Z` held stable, `o_ADD_Z_ACK`=0, and no new grant; release ACK and the arbiter returns to IDLE.
- **Reset during WAIT_Z.** Assert reset during WAIT_Z, then request again. Expect all outputs reset, the stale adder result drained and never delivered, and the next request returning its own correct sum.
- **Counter wrap.** Run with `P_CNT_W`=4 for 17 operations. Expect `o_OP_CNT`=1 after the 17th operation.
